// File: rtl/board_shot_resolver_pkg.sv
// Shared cell codes, result codes and FSM encoding for the battleship board resolver.
package battleship_pkg;

    localparam int CELL_W = 2;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_HIT   = 2'b10,
        CELL_MISS  = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        RES_MISS    = 2'b00,
        RES_HIT     = 2'b01,
        RES_REPEAT  = 2'b10,
        RES_INVALID = 2'b11
    } res_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_UPDATE = 2'b10
    } state_t;

    // Outcome of firing at an in-range cell currently holding code c.
    function automatic res_t shot_result(input logic [1:0] c);
        res_t r;
        case (c)
            CELL_SHIP:  r = RES_HIT;
            CELL_EMPTY: r = RES_MISS;
            default:    r = RES_REPEAT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/board_shot_resolver_if.sv
// Shot request / result bundle between the player-input FSM and the board resolver.
interface board_shot_if #(
    parameter int ROW_W = 3,
    parameter int COL_W = 3,
    parameter int CNT_W = 7
);
    logic             shot_valid;
    logic             shot_ready;
    logic [ROW_W-1:0] shot_row;
    logic [COL_W-1:0] shot_col;
    logic             res_valid;
    logic [1:0]       res_code;
    logic [CNT_W-1:0] ships_left;
    logic             game_over;

    modport master (
        output shot_valid, shot_row, shot_col,
        input  shot_ready, res_valid, res_code, ships_left, game_over
    );

    modport slave (
        input  shot_valid, shot_row, shot_col,
        output shot_ready, res_valid, res_code, ships_left, game_over
    );
endinterface

// File: rtl/board_shot_resolver_cell_mux.sv
// Generalised cell selector: picks one W-bit cell out of a flat N x W vector; out-of-range gives zero.
module board_cell_mux #(
    parameter int N     = 64,
    parameter int W     = 2,
    parameter int IDX_W = 7
) (
    input  logic [N*W-1:0]  flat_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [W-1:0]    cell_o
);

    // AND-OR select so that an index matching no cell leaves the output at zero.
    always_comb begin
        cell_o = '0;
        for (int i = 0; i < N; i++) begin
            cell_o = cell_o | (flat_i[i*W +: W] & {W{idx_i == IDX_W'(i)}});
        end
    end

endmodule

// File: rtl/board_shot_resolver.sv
// Battleship board store and shot resolver: ship placement, 2-cycle shot classification,
// ship counting with sticky game-over, and a registered display read port.
module board_shot_resolver
    import battleship_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ROW_W = 3,
    parameter int COL_W = 3,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [ROW_W-1:0] load_row,
    input  logic [COL_W-1:0] load_col,
    board_shot_if.slave      shot_if,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [1:0]       rd_cell
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(N);
    localparam logic [CNT_W-1:0] SHIP_MAX = CNT_W'(N);

    // Linear cell index, or IDX_NONE when the coordinate lies off the board.
    function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        logic [IDX_W-1:0] idx;
        if ((int'(r) < ROWS) && (int'(c) < COLS)) begin
            idx = IDX_W'(int'(r) * COLS + int'(c));
        end else begin
            idx = IDX_NONE;
        end
        return idx;
    endfunction

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                res_valid_q, res_valid_d;
    res_t                res_code_q, res_code_d;
    logic [CNT_W-1:0]    ships_left_q, ships_left_d;
    logic                game_over_q, game_over_d;
    logic                wr_pend_q, wr_pend_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    cell_t               wr_val_q, wr_val_d;
    logic [N*CELL_W-1:0] board_q, board_d;
    logic [1:0]          rd_cell_q;

    logic             shot_ready_s;
    logic             accept_s;
    logic             load_we_s;
    logic             upd_we_s;
    logic [IDX_W-1:0] load_idx_s;
    logic [IDX_W-1:0] shot_idx_s;
    logic [IDX_W-1:0] look_idx_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [1:0]       look_cell_s;
    logic [1:0]       rd_cell_s;
    logic [N-1:0]     cell_we_s;
    logic [1:0]       cell_wdata_s;

    assign shot_ready_s = rst_n && (state_q == ST_IDLE) && !game_over_q && !clear;
    assign accept_s     = shot_if.shot_valid && shot_ready_s;
    assign load_idx_s   = cell_index(load_row, load_col);
    assign shot_idx_s   = cell_index(row_q, col_q);
    assign rd_idx_s     = cell_index(rd_row, rd_col);
    // The lookup port serves the load occupancy check while idle and the in-flight shot otherwise.
    assign look_idx_s   = (state_q == ST_IDLE) ? load_idx_s : shot_idx_s;
    assign upd_we_s     = (state_q == ST_UPDATE) && wr_pend_q;

    board_cell_mux #(.N(N), .W(CELL_W), .IDX_W(IDX_W)) u_look_mux (
        .flat_i (board_q),
        .idx_i  (look_idx_s),
        .cell_o (look_cell_s)
    );

    board_cell_mux #(.N(N), .W(CELL_W), .IDX_W(IDX_W)) u_rd_mux (
        .flat_i (board_q),
        .idx_i  (rd_idx_s),
        .cell_o (rd_cell_s)
    );

    // Shot FSM, placement acceptance and result / counter next-state.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        res_valid_d  = 1'b0;
        res_code_d   = res_code_q;
        ships_left_d = ships_left_q;
        game_over_d  = game_over_q;
        wr_pend_d    = 1'b0;
        wr_idx_d     = wr_idx_q;
        wr_val_d     = wr_val_q;
        load_we_s    = 1'b0;
        if (clear) begin
            state_d      = ST_IDLE;
            ships_left_d = '0;
            game_over_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        row_d   = shot_if.shot_row;
                        col_d   = shot_if.shot_col;
                        state_d = ST_LOOKUP;
                    end else if (load_valid && !game_over_q && (load_idx_s != IDX_NONE) &&
                                 (look_cell_s == CELL_EMPTY)) begin
                        load_we_s = 1'b1;
                        if (ships_left_q != SHIP_MAX) begin
                            ships_left_d = ships_left_q + CNT_W'(1);
                        end else begin
                            ships_left_d = ships_left_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    // Result and counters are registered here so they appear together in UPDATE.
                    state_d     = ST_UPDATE;
                    res_valid_d = 1'b1;
                    wr_idx_d    = shot_idx_s;
                    if (shot_idx_s == IDX_NONE) begin
                        res_code_d = RES_INVALID;
                    end else begin
                        res_code_d = shot_result(look_cell_s);
                        case (shot_result(look_cell_s))
                            RES_HIT: begin
                                wr_pend_d = 1'b1;
                                wr_val_d  = CELL_HIT;
                                if (ships_left_q != '0) begin
                                    ships_left_d = ships_left_q - CNT_W'(1);
                                end else begin
                                    ships_left_d = ships_left_q;
                                end
                                if (ships_left_q == CNT_W'(1)) begin
                                    game_over_d = 1'b1;
                                end else begin
                                    game_over_d = game_over_q;
                                end
                            end
                            RES_MISS: begin
                                wr_pend_d = 1'b1;
                                wr_val_d  = CELL_MISS;
                            end
                            default: begin
                                wr_pend_d = 1'b0;
                            end
                        endcase
                    end
                end
                ST_UPDATE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // One-hot cell write enable: placement and shot-update writes are mutually exclusive by state.
    always_comb begin
        cell_we_s    = '0;
        cell_wdata_s = CELL_EMPTY;
        if (load_we_s) begin
            cell_wdata_s = CELL_SHIP;
            for (int i = 0; i < N; i++) begin
                cell_we_s[i] = (load_idx_s == IDX_W'(i));
            end
        end else if (upd_we_s) begin
            cell_wdata_s = wr_val_q;
            for (int i = 0; i < N; i++) begin
                cell_we_s[i] = (wr_idx_q == IDX_W'(i));
            end
        end else begin
            cell_we_s = '0;
        end
    end

    // Board next-state: clear wipes everything, otherwise only the enabled cell changes.
    always_comb begin
        board_d = board_q;
        for (int i = 0; i < N; i++) begin
            if (clear) begin
                board_d[i*CELL_W +: CELL_W] = CELL_EMPTY;
            end else if (cell_we_s[i]) begin
                board_d[i*CELL_W +: CELL_W] = cell_wdata_s;
            end else begin
                board_d[i*CELL_W +: CELL_W] = board_q[i*CELL_W +: CELL_W];
            end
        end
    end

    // State, board and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            res_valid_q  <= 1'b0;
            res_code_q   <= RES_MISS;
            ships_left_q <= '0;
            game_over_q  <= 1'b0;
            wr_pend_q    <= 1'b0;
            wr_idx_q     <= '0;
            wr_val_q     <= CELL_EMPTY;
            board_q      <= '0;
            rd_cell_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            res_valid_q  <= res_valid_d;
            res_code_q   <= res_code_d;
            ships_left_q <= ships_left_d;
            game_over_q  <= game_over_d;
            wr_pend_q    <= wr_pend_d;
            wr_idx_q     <= wr_idx_d;
            wr_val_q     <= wr_val_d;
            board_q      <= board_d;
            rd_cell_q    <= rd_cell_s;
        end
    end

    assign shot_if.shot_ready = shot_ready_s;
    assign shot_if.res_valid  = res_valid_q;
    assign shot_if.res_code   = res_code_q;
    assign shot_if.ships_left = ships_left_q;
    assign shot_if.game_over  = game_over_q;
    assign rd_cell            = rd_cell_q;

endmodule

// File: tb/tb_board_shot_resolver.sv
// Bench for board_shot_resolver: an 8x8 and a 6x8 board share one stimulus stream and are
// checked every cycle against a game-level model, plus hand-computed directed expectations.
module tb_board_shot_resolver;

    localparam logic [1:0] C_E = 2'b00, C_S = 2'b01, C_H = 2'b10, C_M = 2'b11;
    localparam logic [1:0] R_MISS = 2'b00, R_HIT = 2'b01, R_REP = 2'b10, R_INV = 2'b11;
    localparam int COLS_M = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       load_valid = 1'b0;
    logic [2:0] load_row = 3'd0, load_col = 3'd0;
    logic       shot_valid = 1'b0;
    logic [2:0] shot_row = 3'd0, shot_col = 3'd0;
    logic [2:0] rd_row = 3'd0, rd_col = 3'd0;
    logic [1:0] rd_cell8, rd_cell6;
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    board_shot_if #(.ROW_W(3), .COL_W(3), .CNT_W(7)) sif8 ();
    board_shot_if #(.ROW_W(3), .COL_W(3), .CNT_W(7)) sif6 ();

    assign sif8.shot_valid = shot_valid;
    assign sif8.shot_row   = shot_row;
    assign sif8.shot_col   = shot_col;
    assign sif6.shot_valid = shot_valid;
    assign sif6.shot_row   = shot_row;
    assign sif6.shot_col   = shot_col;

    board_shot_resolver #(.ROWS(8), .COLS(8), .ROW_W(3), .COL_W(3), .CNT_W(7)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid),
        .load_row(load_row), .load_col(load_col), .shot_if(sif8),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell8)
    );

    board_shot_resolver #(.ROWS(6), .COLS(8), .ROW_W(3), .COL_W(3), .CNT_W(7)) dut6 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid),
        .load_row(load_row), .load_col(load_col), .shot_if(sif6),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell6)
    );

    logic       act_rv [2];
    logic       act_sr [2];
    logic       act_go [2];
    logic [1:0] act_rc [2];
    logic [1:0] act_rd [2];
    logic [6:0] act_sl [2];
    assign act_rv[0] = sif8.res_valid;  assign act_rv[1] = sif6.res_valid;
    assign act_sr[0] = sif8.shot_ready; assign act_sr[1] = sif6.shot_ready;
    assign act_go[0] = sif8.game_over;  assign act_go[1] = sif6.game_over;
    assign act_rc[0] = sif8.res_code;   assign act_rc[1] = sif6.res_code;
    assign act_rd[0] = rd_cell8;        assign act_rd[1] = rd_cell6;
    assign act_sl[0] = sif8.ships_left; assign act_sl[1] = sif6.ships_left;

    // Game-level model: board contents, ship count, game over, and the one shot in flight
    // (busy counts the edges until the shot's result strobe has come and gone).
    int         rows_m [2] = '{8, 6};
    logic [1:0] mb [2][8][8];
    int         ships [2];
    bit         go [2];
    int         busy [2];
    int         sr_m [2], sc_m [2];
    bit         pend [2];
    logic [1:0] pv [2];
    bit         rv_m [2];
    logic [1:0] rc_m [2];
    logic [1:0] rd_m [2];

    function automatic bit in_range(input int b, input int r, input int c);
        return (r < rows_m[b]) && (c < COLS_M);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic wipe(input int b);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                mb[b][r][c] = C_E;
            end
        end
        ships[b] = 0;
        go[b]    = 1'b0;
        busy[b]  = 0;
        pend[b]  = 1'b0;
        rv_m[b]  = 1'b0;
    endtask

    task automatic model_edge();
        bit acc;
        for (int b = 0; b < 2; b++) begin
            if (!rst_n) begin
                wipe(b);
                rc_m[b] = R_MISS;
                rd_m[b] = C_E;
            end else begin
                rd_m[b] = in_range(b, rd_row, rd_col) ? mb[b][rd_row][rd_col] : C_E;
                acc = shot_valid && (busy[b] == 0) && !go[b] && !clear;
                if (clear) begin
                    wipe(b);
                end else if (busy[b] == 2) begin
                    rv_m[b] = 1'b1;
                    busy[b] = 1;
                    if (!in_range(b, sr_m[b], sc_m[b])) begin
                        rc_m[b] = R_INV;
                    end else if (mb[b][sr_m[b]][sc_m[b]] == C_S) begin
                        rc_m[b] = R_HIT;
                        pend[b] = 1'b1; pv[b] = C_H;
                        ships[b] = ships[b] - 1;
                        if (ships[b] == 0) go[b] = 1'b1;
                    end else if (mb[b][sr_m[b]][sc_m[b]] == C_E) begin
                        rc_m[b] = R_MISS;
                        pend[b] = 1'b1; pv[b] = C_M;
                    end else begin
                        rc_m[b] = R_REP;
                    end
                end else if (busy[b] == 1) begin
                    if (pend[b]) mb[b][sr_m[b]][sc_m[b]] = pv[b];
                    pend[b] = 1'b0;
                    rv_m[b] = 1'b0;
                    busy[b] = 0;
                end else if (acc) begin
                    sr_m[b] = int'(shot_row);
                    sc_m[b] = int'(shot_col);
                    busy[b] = 2;
                end else if (load_valid && !go[b] && in_range(b, load_row, load_col) &&
                             mb[b][load_row][load_col] == C_E) begin
                    mb[b][load_row][load_col] = C_S;
                    if (ships[b] < rows_m[b] * COLS_M) ships[b] = ships[b] + 1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_edge();
        end
    end

    // Per-cycle comparison of both boards against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int b = 0; b < 2; b++) begin
                    check($sformatf("res_valid[%0d]", b), act_rv[b], rv_m[b]);
                    if (rv_m[b]) check($sformatf("res_code[%0d]", b), act_rc[b], rc_m[b]);
                    check($sformatf("ships_left[%0d]", b), act_sl[b], ships[b]);
                    check($sformatf("game_over[%0d]", b), act_go[b], go[b]);
                    check($sformatf("rd_cell[%0d]", b), act_rd[b], rd_m[b]);
                    check($sformatf("shot_ready[%0d]", b), act_sr[b],
                          rst_n && (busy[b] == 0) && !go[b] && !clear);
                end
            end
        end
    end

    task automatic drv(input bit cl, input bit lv, input int lr, input int lc,
                       input bit sv, input int sr, input int sc);
        @(posedge clk);
        #2;
        clear      = cl;
        load_valid = lv;
        load_row   = 3'(lr);
        load_col   = 3'(lc);
        shot_valid = sv;
        shot_row   = 3'(sr);
        shot_col   = 3'(sc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic shoot(input int r, input int c);
        drv(1'b0, 1'b0, 0, 0, 1'b1, r, c);
        idle(2);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_res_valid", sif8.res_valid, 1'b0);
        check("reset_ships", sif8.ships_left, 7'd0);
        check("reset_rd_cell", rd_cell8, 2'b00);

        // Two ships, then a hit on the first.
        drv(1'b0, 1'b1, 2, 3, 1'b0, 0, 0);
        drv(1'b0, 1'b1, 2, 4, 1'b0, 0, 0);
        idle(1);
        @(negedge clk);
        check("t1_ships_after_load", sif8.ships_left, 7'd2);
        shoot(2, 3);
        check("t1_res_valid", sif8.res_valid, 1'b1);
        check("t1_hit", sif8.res_code, R_HIT);
        check("t1_ships_after_hit", sif8.ships_left, 7'd1);
        rd_row = 3'd2; rd_col = 3'd3;
        idle(3);
        @(negedge clk);
        check("t1_rd_hit", rd_cell8, C_H);

        // Miss, then repeat on the same cell.
        shoot(0, 0);
        check("t2_miss", sif8.res_code, R_MISS);
        shoot(0, 0);
        check("t2_repeat", sif8.res_code, R_REP);
        rd_row = 3'd0; rd_col = 3'd0;
        idle(3);
        @(negedge clk);
        check("t2_rd_miss", rd_cell8, C_M);
        check("t2_ships", sif8.ships_left, 7'd1);

        // Board edges: row 6/7 valid on 8 rows, invalid on 6 rows.
        shoot(7, 7);
        check("t3_8x8_corner", sif8.res_code, R_MISS);
        check("t3_6x8_corner", sif6.res_code, R_INV);
        shoot(6, 0);
        check("t3_6x8_row6", sif6.res_code, R_INV);
        rd_row = 3'd6; rd_col = 3'd0;
        idle(3);
        @(negedge clk);
        check("t3_8x8_rd", rd_cell8, C_M);
        check("t3_6x8_rd", rd_cell6, C_E);
        check("t3_6x8_ships", sif6.ships_left, 7'd1);

        // Last ship sinks: game over, loads ignored, clear recovers.
        shoot(2, 4);
        check("t4_hit_last", sif8.res_code, R_HIT);
        check("t4_game_over", sif8.game_over, 1'b1);
        check("t4_ships_zero", sif8.ships_left, 7'd0);
        idle(2);
        @(negedge clk);
        check("t4_not_ready", sif8.shot_ready, 1'b0);
        drv(1'b0, 1'b1, 3, 3, 1'b0, 0, 0);
        idle(1);
        @(negedge clk);
        check("t4_load_ignored", sif8.ships_left, 7'd0);
        drv(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        idle(1);
        @(negedge clk);
        check("t4_clear_go", sif8.game_over, 1'b0);
        check("t4_clear_ready", sif8.shot_ready, 1'b1);

        // Duplicate load counts once; shot beats a simultaneous load.
        drv(1'b0, 1'b1, 1, 1, 1'b0, 0, 0);
        drv(1'b0, 1'b1, 1, 1, 1'b0, 0, 0);
        idle(1);
        @(negedge clk);
        check("t5_dup_load", sif8.ships_left, 7'd1);
        drv(1'b0, 1'b1, 4, 4, 1'b1, 5, 5);
        idle(2);
        @(negedge clk);
        check("t5_shot_wins", sif8.res_code, R_MISS);
        check("t5_load_dropped", sif8.ships_left, 7'd1);
        rd_row = 3'd4; rd_col = 3'd4;
        idle(3);
        @(negedge clk);
        check("t5_rd_empty", rd_cell8, C_E);

        // Clear during LOOKUP aborts the shot.
        drv(1'b0, 1'b0, 0, 0, 1'b1, 1, 1);
        drv(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            @(negedge clk);
            check("t6_no_strobe_after_clear", sif8.res_valid, 1'b0);
        end
        check("t6_clear_ships", sif8.ships_left, 7'd0);

        // Asynchronous reset in the UPDATE cycle.
        drv(1'b0, 1'b1, 1, 1, 1'b0, 0, 0);
        shoot(1, 1);
        check("t6_update_strobe", sif8.res_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_res_valid", sif8.res_valid, 1'b0);
        check("t6_rst_res_code", sif8.res_code, 2'b00);
        check("t6_rst_go", sif8.game_over, 1'b0);
        check("t6_rst_ready", sif8.shot_ready, 1'b0);
        check("t6_rst_rd", rd_cell8, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_strobe_after_rst", sif8.res_valid, 1'b0);
        end

        // Randomized traffic; alternating small-area phases drive frequent game-overs.
        for (int i = 0; i < 3000; i++) begin
            lim = ((i / 150) % 2 == 1) ? 1 : 7;
            @(posedge clk);
            #2;
            clear      = ($urandom_range(0, 99) < 2);
            load_valid = ($urandom_range(0, 99) < 40);
            load_row   = 3'($urandom_range(0, lim));
            load_col   = 3'($urandom_range(0, lim));
            shot_valid = ($urandom_range(0, 99) < 35);
            shot_row   = 3'($urandom_range(0, lim));
            shot_col   = 3'($urandom_range(0, lim));
            rd_row     = 3'($urandom_range(0, 7));
            rd_col     = 3'($urandom_range(0, 7));
        end
        idle(4);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
